// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX scheduler slice.
//   UART_KEYWORD        sync byte that opens every session with the peer receiver
//   PEER_TIMEOUT_TICKS  peer declares con_broken after this many silent clk_ticks
//   WORD_W              width of one game-state word (sent as MSB byte, then LSB byte)
//   IDLE_CNT_W          width of the keepalive idle counter
//   state_e             scheduler FSM states
package uart_pkg;

  localparam logic [7:0] UART_KEYWORD       = 8'h0F;
  localparam int         PEER_TIMEOUT_TICKS = 64;
  localparam int         WORD_W             = 16;
  localparam int         IDLE_CNT_W         = 6;

  typedef enum logic [1:0] {
    SYNC     = 2'd0,
    IDLE     = 2'd1,
    SEND_MSB = 2'd2,
    SEND_LSB = 2'd3
  } state_e;

  function automatic logic [7:0] word_msb(input logic [WORD_W-1:0] w);
    return w[15:8];
  endfunction

  function automatic logic [7:0] word_lsb(input logic [WORD_W-1:0] w);
    return w[7:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first set request at or after ptr_i, wrapping modulo N, and
// reports the pointer value that follows the winner. The pointer register
// itself is owned by the caller, so this block holds no state.
// Ports:
//   req_i       request vector
//   ptr_i       current round-robin start index
//   gnt_o       one-hot grant (all zero when no request)
//   next_ptr_o  winner index + 1 modulo N (equals ptr_i when no request)
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [PTR_W-1:0] next_ptr_o
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt_o      = '0;
    next_ptr_o = ptr_i;
    found      = 1'b0;
    idx        = '0;
    for (int k = 0; k < N; k++) begin
      idx = PTR_W'((int'(ptr_i) + k) % N);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        next_ptr_o = PTR_W'((int'(idx) + 1) % N);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one byte-wide UART transmitter between NUM_REQ 16-bit word sources.
// A session opens with the keyword byte 8'h0F; each granted word then goes
// out as MSB byte followed by LSB byte, never split, so the peer's pairing
// (keyword -> MSB -> LSB -> MSB ...) stays aligned.
//
// Optional feature: define UART_TX_SCHED_KEEPALIVE_EN to resend the last
// word after KEEPALIVE_TICKS idle clk_ticks. KEEPALIVE_TICKS must stay below
// PEER_TIMEOUT_TICKS (64) or the peer times out before the keepalive lands.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   clk_tick     baud tick, timebase of the keepalive idle counter
//   req          per-source request, held until granted
//   req_data     word i at [16*i+15:16*i]
//   gnt          one-hot 1-cycle pulse: word i latched this cycle
//   resync_req   pulse: resend keyword (deferred until a word in flight is done)
//   tx_full      TX FIFO full
//   tx_wr        TX FIFO write strobe, tx_din valid in the same cycle
//   tx_din       byte to write
//   synced       keyword written since last reset/resync
//   state_dbg    current FSM state
//
// Handshakes: a source raises req[i] with stable data and holds both until
// it sees gnt[i] high in a cycle; that cycle's clock edge latches the word.
// On the FIFO side a byte is transferred exactly in a cycle where tx_wr=1,
// and tx_wr is only raised when tx_full=0; while tx_full=1 the FSM waits.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int KEEPALIVE_TICKS = 48
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clk_tick,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [WORD_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  input  logic                      resync_req,
  input  logic                      tx_full,
  output logic                      tx_wr,
  output logic [7:0]                tx_din,
  output logic                      synced,
  output state_e                    state_dbg
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                synced_q, synced_d;
  logic                resync_pend_q, resync_pend_d;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [PTR_W-1:0]    arb_next_ptr;
  logic [WORD_W-1:0]   arb_word;
  logic                ka_fire;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req_i      (req),
    .ptr_i      (rr_ptr_q),
    .gnt_o      (arb_gnt),
    .next_ptr_o (arb_next_ptr)
  );

  // Word of the winning source; arb_gnt is one-hot so an OR-mux suffices.
  always_comb begin
    arb_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) arb_word = arb_word | req_data[WORD_W*i +: WORD_W];
    end
  end

`ifdef UART_TX_SCHED_KEEPALIVE_EN
  localparam logic [IDLE_CNT_W-1:0] KA_LAST = IDLE_CNT_W'(KEEPALIVE_TICKS - 1);

  logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;

  // Counts clk_ticks spent quietly in IDLE. Anything that takes the FSM out
  // of IDLE (req, resync, or a byte write elsewhere) restarts the count, so
  // a real request always wins over the keepalive in the same cycle.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    ka_fire    = 1'b0;
    if (state_q != IDLE || resync_req || (|req)) begin
      idle_cnt_d = '0;
    end else if (clk_tick) begin
      if (idle_cnt_q == KA_LAST) begin
        ka_fire    = 1'b1;
        idle_cnt_d = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) idle_cnt_q <= '0;
    else     idle_cnt_q <= idle_cnt_d;
  end
`else
  // Keepalive disabled: the line stays silent when idle and recovery
  // relies on the peer requesting a resync.
  logic unused_keepalive;
  assign ka_fire          = 1'b0;
  assign unused_keepalive = clk_tick ^ (KEEPALIVE_TICKS == 0);
`endif

  // Next state and outputs. Outputs are forced quiet while rst is high so
  // nothing reaches the FIFO during reset.
  always_comb begin
    state_d       = state_q;
    word_d        = word_q;
    rr_ptr_d      = rr_ptr_q;
    synced_d      = synced_q;
    resync_pend_d = resync_pend_q;
    gnt           = '0;
    tx_wr         = 1'b0;
    tx_din        = '0;

    if (!rst) begin
      case (state_q)
        SYNC: begin
          // resync_req is ignored here: exactly one keyword per resync.
          if (!tx_full) begin
            tx_wr    = 1'b1;
            tx_din   = UART_KEYWORD;
            synced_d = 1'b1;
            state_d  = IDLE;
          end
        end

        IDLE: begin
          if (resync_req) begin
            synced_d = 1'b0;
            state_d  = SYNC;
          end else if (|req) begin
            gnt      = arb_gnt;
            word_d   = arb_word;
            rr_ptr_d = arb_next_ptr;
            state_d  = SEND_MSB;
          end else if (ka_fire) begin
            // Resend of word_q; no source is granted.
            state_d = SEND_MSB;
          end
        end

        SEND_MSB: begin
          if (resync_req) resync_pend_d = 1'b1;
          if (!tx_full) begin
            tx_wr   = 1'b1;
            tx_din  = word_msb(word_q);
            state_d = SEND_LSB;
          end
        end

        SEND_LSB: begin
          if (!tx_full) begin
            tx_wr  = 1'b1;
            tx_din = word_lsb(word_q);
            // A resync seen during the word is honoured only now, after
            // the LSB, so the peer never sees half a word.
            if (resync_pend_q || resync_req) begin
              resync_pend_d = 1'b0;
              synced_d      = 1'b0;
              state_d       = SYNC;
            end else begin
              state_d = IDLE;
            end
          end else if (resync_req) begin
            resync_pend_d = 1'b1;
          end
        end

        default: state_d = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= SYNC;
      word_q        <= '0;
      rr_ptr_q      <= '0;
      synced_q      <= 1'b0;
      resync_pend_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_q        <= word_d;
      rr_ptr_q      <= rr_ptr_d;
      synced_q      <= synced_d;
      resync_pend_q <= resync_pend_d;
    end
  end

  assign synced    = synced_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Testbench for uart_tx_scheduler. Inputs change 2 time units after the
// rising edge; a monitor samples outputs on the falling edge and logs every
// byte write and grant with a cycle stamp. Each test task compares the logs
// against its own hand-computed expectations.
module tb_uart_tx_scheduler;
  import uart_pkg::*;

  localparam int NUM_REQ = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 clk_tick;
  logic [NUM_REQ-1:0]   req;
  logic [16*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   gnt;
  logic                 resync_req;
  logic                 tx_full;
  logic                 tx_wr;
  logic [7:0]           tx_din;
  logic                 synced;
  state_e               state_dbg;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [7:0]         byte_log[$];
  int                 byte_cyc[$];
  logic [NUM_REQ-1:0] gnt_log[$];
  int                 gnt_cyc[$];
  logic [7:0]         exp_q[$];

  uart_tx_scheduler #(.NUM_REQ(NUM_REQ), .KEEPALIVE_TICKS(48)) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_tick   (clk_tick),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .resync_req (resync_req),
    .tx_full    (tx_full),
    .tx_wr      (tx_wr),
    .tx_din     (tx_din),
    .synced     (synced),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (tx_wr === 1'b1) begin
        byte_log.push_back(tx_din);
        byte_cyc.push_back(cyc);
      end
      if (gnt !== '0) begin
        gnt_log.push_back(gnt);
        gnt_cyc.push_back(cyc);
      end
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Runs until n bytes are logged; acts as every source, dropping req[i]
  // after its grant.
  task automatic run_bytes(input int n, input int budget, output bit ok);
    logic [NUM_REQ-1:0] g;
    int b;
    b = budget;
    while (byte_log.size() < n && b > 0) begin
      @(negedge clk);
      g = gnt;
      @(posedge clk);
      #2;
      req = req & ~g;
      b--;
    end
    ok = (byte_log.size() >= n);
  endtask

  task automatic wait_gnt(input int budget, output logic [NUM_REQ-1:0] g, output bit ok);
    int b;
    b  = budget;
    g  = '0;
    ok = 1'b0;
    while (!ok && b > 0) begin
      @(negedge clk);
      g = gnt;
      @(posedge clk);
      #2;
      req = req & ~g;
      ok  = (g !== '0);
      b--;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bit ok, bad;
    logic [7:0] a;
    rst = 1'b1; req = '0; req_data = '0; resync_req = 1'b0; clk_tick = 1'b0; tx_full = 1'b0;
    repeat (3) step();
    @(negedge clk);
    checks++; if (tx_wr !== 1'b0) begin errors++; $display("FAIL reset_tx_wr: got %b expected 0", tx_wr); end
    checks++; if (tx_din !== 8'h00) begin errors++; $display("FAIL reset_tx_din: got %02h expected 00", tx_din); end
    checks++; if (gnt !== '0) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    checks++; if (synced !== 1'b0) begin errors++; $display("FAIL reset_synced: got %b expected 0", synced); end
    checks++; if (state_dbg !== SYNC) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, SYNC); end
    step();
    // Out of reset with the FIFO full and a request waiting: nothing may happen.
    rst = 1'b0; tx_full = 1'b1; req = 4'b0001;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (tx_wr !== 1'b0 || gnt !== '0 || synced !== 1'b0) bad = 1'b1;
    end
    @(posedge clk); #2;
    checks++; if (bad) begin errors++; $display("FAIL hold_before_keyword: activity seen while FIFO full, expected none"); end
    req = '0; tx_full = 1'b0;
    run_bytes(1, 5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL keyword_timeout: got %0d bytes expected 1", byte_log.size()); end
    if (ok) begin
      a = byte_log.pop_front(); void'(byte_cyc.pop_front());
      checks++; if (a !== 8'h0F) begin errors++; $display("FAIL keyword_byte: got %02h expected 0f", a); end
    end
    @(negedge clk);
    checks++; if (synced !== 1'b1) begin errors++; $display("FAIL synced_after_keyword: got %b expected 1", synced); end
    checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL state_after_keyword: got %0d expected %0d", state_dbg, IDLE); end
    @(posedge clk); #2;
  endtask

  task automatic test_single_word();
    bit ok;
    int k, gc;
    int bc[2];
    logic [7:0] a, e;
    logic [NUM_REQ-1:0] g;
    bc[0] = -1; bc[1] = -1; gc = -100;
    req_data[47:32] = 16'hA55A; req = 4'b0100;
    run_bytes(2, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got %0d bytes expected 2", byte_log.size()); end
    exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (byte_log.size() == 0) begin errors++; $display("FAIL single_byte%0d: got none expected %02h", k, e); end
      else begin
        a = byte_log.pop_front(); bc[k] = byte_cyc.pop_front();
        if (a !== e) begin errors++; $display("FAIL single_byte%0d: got %02h expected %02h", k, a, e); end
      end
      k++;
    end
    checks++;
    if (gnt_log.size() != 1) begin errors++; $display("FAIL single_gnt_count: got %0d expected 1", gnt_log.size()); end
    else begin
      g = gnt_log.pop_front(); gc = gnt_cyc.pop_front();
      if (g !== 4'b0100) begin errors++; $display("FAIL single_gnt: got %b expected 0100", g); end
    end
    checks++; if (bc[0] != gc + 1) begin errors++; $display("FAIL single_msb_latency: got cycle %0d expected %0d", bc[0], gc + 1); end
    checks++; if (bc[1] != gc + 2) begin errors++; $display("FAIL single_lsb_latency: got cycle %0d expected %0d", bc[1], gc + 2); end
    @(negedge clk);
    checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL single_back_to_idle: got %0d expected %0d", state_dbg, IDLE); end
    @(posedge clk); #2;
  endtask

  task automatic test_round_robin();
    bit ok;
    int k;
    int gcs[5];
    logic [7:0] a, e;
    logic [NUM_REQ-1:0] g;
    logic [NUM_REQ-1:0] exp_g[5];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    for (int i = 0; i < 5; i++) gcs[i] = 0;
    // Fresh reset so the pointer starts at 0.
    rst = 1'b1; req = '0; resync_req = 1'b0;
    repeat (3) step();
    req_data = {16'h13A3, 16'h12A2, 16'h11A1, 16'h10A0};
    rst = 1'b0; tx_full = 1'b0; req = 4'b1111;
    run_bytes(3, 20, ok);
    // Source 0 comes back with a new word; it must wait behind 1,2,3.
    req_data[15:0] = 16'h7E81; req[0] = 1'b1;
    run_bytes(11, 60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_timeout: got %0d bytes expected 11", byte_log.size()); end
    exp_q.push_back(8'h0F);
    exp_q.push_back(8'h10); exp_q.push_back(8'hA0);
    exp_q.push_back(8'h11); exp_q.push_back(8'hA1);
    exp_q.push_back(8'h12); exp_q.push_back(8'hA2);
    exp_q.push_back(8'h13); exp_q.push_back(8'hA3);
    exp_q.push_back(8'h7E); exp_q.push_back(8'h81);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (byte_log.size() == 0) begin errors++; $display("FAIL rr_byte%0d: got none expected %02h", k, e); end
      else begin
        a = byte_log.pop_front(); void'(byte_cyc.pop_front());
        if (a !== e) begin errors++; $display("FAIL rr_byte%0d: got %02h expected %02h", k, a, e); end
      end
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (gnt_log.size() == 0) begin errors++; $display("FAIL rr_gnt%0d: got none expected %b", i, exp_g[i]); end
      else begin
        g = gnt_log.pop_front(); gcs[i] = gnt_cyc.pop_front();
        if (g !== exp_g[i]) begin errors++; $display("FAIL rr_gnt%0d: got %b expected %b", i, g, exp_g[i]); end
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (gcs[i+1] - gcs[i] != 3) begin errors++; $display("FAIL rr_spacing%0d: got %0d cycles expected 3", i, gcs[i+1] - gcs[i]); end
    end
  endtask

  task automatic test_stall();
    bit ok, bad;
    int rel, lc;
    logic [7:0] a;
    logic [NUM_REQ-1:0] g;
    lc = -1;
    req_data[31:16] = 16'h6C93; req = 4'b0010;
    run_bytes(1, 20, ok);
    // Now in the cycle that would write the LSB: stall it for 10 cycles.
    tx_full = 1'b1;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (tx_wr !== 1'b0 || state_dbg !== SEND_LSB) bad = 1'b1;
    end
    @(posedge clk); #2;
    checks++; if (bad) begin errors++; $display("FAIL stall_hold: write or state change seen while FIFO full, expected none"); end
    tx_full = 1'b0; rel = cyc;
    run_bytes(2, 5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_timeout: got %0d bytes expected 2", byte_log.size()); end
    if (ok) begin
      a = byte_log.pop_front(); void'(byte_cyc.pop_front());
      checks++; if (a !== 8'h6C) begin errors++; $display("FAIL stall_msb: got %02h expected 6c", a); end
      a = byte_log.pop_front(); lc = byte_cyc.pop_front();
      checks++; if (a !== 8'h93) begin errors++; $display("FAIL stall_lsb: got %02h expected 93", a); end
      checks++; if (lc != rel) begin errors++; $display("FAIL stall_release_cycle: got %0d expected %0d", lc, rel); end
    end
    checks++;
    if (gnt_log.size() == 0) begin errors++; $display("FAIL stall_gnt: got none expected 0010"); end
    else begin
      g = gnt_log.pop_front(); void'(gnt_cyc.pop_front());
      if (g !== 4'b0010) begin errors++; $display("FAIL stall_gnt: got %b expected 0010", g); end
    end
  endtask

  task automatic test_resync_mid_word();
    bit ok;
    int k, kc, gc;
    logic [7:0] a, e;
    logic [NUM_REQ-1:0] g;
    kc = -1; gc = -1;
    req_data[63:48] = 16'h1234; req = 4'b1000;
    wait_gnt(20, g, ok);
    checks++; if (!ok || g !== 4'b1000) begin errors++; $display("FAIL resync_first_gnt: got %b expected 1000", g); end
    // In SEND_MSB: request a resync and queue another word from source 0.
    resync_req = 1'b1; req_data[15:0] = 16'h0BAD; req[0] = 1'b1;
    step();
    resync_req = 1'b0;
    step();
    @(negedge clk);
    checks++; if (synced !== 1'b0 || state_dbg !== SYNC) begin errors++; $display("FAIL resync_sync_state: got synced=%b state=%0d expected synced=0 state=%0d", synced, state_dbg, SYNC); end
    @(posedge clk); #2;
    run_bytes(5, 30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL resync_timeout: got %0d bytes expected 5", byte_log.size()); end
    exp_q.push_back(8'h12); exp_q.push_back(8'h34); exp_q.push_back(8'h0F);
    exp_q.push_back(8'h0B); exp_q.push_back(8'hAD);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (byte_log.size() == 0) begin errors++; $display("FAIL resync_byte%0d: got none expected %02h", k, e); end
      else begin
        a = byte_log.pop_front();
        if (k == 2) kc = byte_cyc.pop_front(); else void'(byte_cyc.pop_front());
        if (a !== e) begin errors++; $display("FAIL resync_byte%0d: got %02h expected %02h", k, a, e); end
      end
      k++;
    end
    checks++;
    if (gnt_log.size() != 2) begin errors++; $display("FAIL resync_gnt_count: got %0d expected 2", gnt_log.size()); end
    else begin
      void'(gnt_log.pop_front()); void'(gnt_cyc.pop_front());
      g = gnt_log.pop_front(); gc = gnt_cyc.pop_front();
      if (g !== 4'b0001) begin errors++; $display("FAIL resync_second_gnt: got %b expected 0001", g); end
    end
    checks++; if (gc != kc + 1) begin errors++; $display("FAIL resync_gnt_after_keyword: got cycle %0d expected %0d", gc, kc + 1); end
    @(negedge clk);
    checks++; if (synced !== 1'b1) begin errors++; $display("FAIL resync_resynced: got %b expected 1", synced); end
    @(posedge clk); #2;
  endtask

  task automatic test_resync_idle();
    bit ok;
    int k;
    logic [7:0] a, e;
    logic [NUM_REQ-1:0] g;
    // Pointer is 1; only source 2 requests. Resync held two cycles: the
    // second cycle lands in SYNC and must not produce a second keyword.
    req_data[47:32] = 16'h4D2E; req = 4'b0100; resync_req = 1'b1;
    @(negedge clk);
    checks++; if (gnt !== '0) begin errors++; $display("FAIL resync_idle_no_gnt: got %b expected 0000", gnt); end
    @(posedge clk); #2;
    step();
    resync_req = 1'b0;
    run_bytes(3, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL resync_idle_timeout: got %0d bytes expected 3", byte_log.size()); end
    exp_q.push_back(8'h0F); exp_q.push_back(8'h4D); exp_q.push_back(8'h2E);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (byte_log.size() == 0) begin errors++; $display("FAIL resync_idle_byte%0d: got none expected %02h", k, e); end
      else begin
        a = byte_log.pop_front(); void'(byte_cyc.pop_front());
        if (a !== e) begin errors++; $display("FAIL resync_idle_byte%0d: got %02h expected %02h", k, a, e); end
      end
      k++;
    end
    checks++;
    if (gnt_log.size() == 0) begin errors++; $display("FAIL resync_idle_gnt: got none expected 0100"); end
    else begin
      g = gnt_log.pop_front(); void'(gnt_cyc.pop_front());
      if (g !== 4'b0100) begin errors++; $display("FAIL resync_idle_gnt: got %b expected 0100", g); end
    end
  endtask

  task automatic test_keepalive();
    bit ok;
    int tc;
    logic [7:0] a;
    int ac;
    req_data[31:16] = 16'hBEEF; req = 4'b0010;
    run_bytes(2, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ka_setup_timeout: got %0d bytes expected 2", byte_log.size()); end
    while (byte_log.size() > 0) begin
      a = byte_log.pop_front(); void'(byte_cyc.pop_front());
    end
    while (gnt_log.size() > 0) begin
      void'(gnt_log.pop_front()); void'(gnt_cyc.pop_front());
    end
    repeat (47) begin
      clk_tick = 1'b1; step();
      clk_tick = 1'b0; step();
    end
    checks++; if (byte_log.size() != 0) begin errors++; $display("FAIL ka_early: got %0d bytes after 47 ticks expected 0", byte_log.size()); end
    tc = cyc;
    clk_tick = 1'b1; step();
    clk_tick = 1'b0;
    repeat (4) step();
`ifdef UART_TX_SCHED_KEEPALIVE_EN
    checks++;
    if (byte_log.size() != 2) begin errors++; $display("FAIL ka_resend_count: got %0d bytes expected 2", byte_log.size()); end
    else begin
      a = byte_log.pop_front(); ac = byte_cyc.pop_front();
      if (a !== 8'hBE) begin errors++; $display("FAIL ka_resend_msb: got %02h expected be", a); end
      checks++; if (ac != tc + 1) begin errors++; $display("FAIL ka_resend_cycle: got %0d expected %0d", ac, tc + 1); end
      a = byte_log.pop_front(); void'(byte_cyc.pop_front());
      checks++; if (a !== 8'hEF) begin errors++; $display("FAIL ka_resend_lsb: got %02h expected ef", a); end
    end
`else
    ac = tc;
    checks++; if (byte_log.size() != 0) begin errors++; $display("FAIL ka_silent: got %0d bytes expected 0 (cycle %0d)", byte_log.size(), ac); end
`endif
    checks++; if (gnt_log.size() != 0) begin errors++; $display("FAIL ka_no_gnt: got %0d grants expected 0", gnt_log.size()); end
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    test_reset();
    test_single_word();
    test_round_robin();
    test_stall();
    test_resync_mid_word();
    test_resync_idle();
    test_keepalive();
    repeat (3) step();
    checks++; if (byte_log.size() != 0) begin errors++; $display("FAIL leftover_bytes: got %0d expected 0", byte_log.size()); end
    checks++; if (gnt_log.size() != 0) begin errors++; $display("FAIL leftover_gnts: got %0d expected 0", gnt_log.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
